// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared constants, state enum and row-slot helper for the image stages
package img_pkg;

  localparam int IMG_DIM   = 64;
  localparam int DW        = 8;
  localparam int ADDR_W    = 6;

  // Kernel weights: centre tap and each of the eight neighbours
  localparam int K_CENTRE  = 9;
  localparam int K_NEIGH   = -1;

  // Output clamp limits
  localparam int CLAMP_MIN = 0;
  localparam int CLAMP_MAX = 255;

  // Accumulator width: covers -2040..2295 as a signed value
  localparam int ACC_W     = 13;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_e;

  // Line-buffer slot for an image row: rows rotate through three slots
  function automatic logic [1:0] slot_of(input logic [ADDR_W:0] r);
    logic [ADDR_W:0] m;
    m = r % 7'd3;
    return m[1:0];
  endfunction

endpackage

// File: rtl/sharpen_kernel.sv
// rtl/sharpen_kernel.sv - combinational 3x3 sharpen kernel with border mask and clamp
module sharpen_kernel
  import img_pkg::*;
(
  input  logic [9*DW-1:0] taps_i,   // tap (dr*3+dc)*DW, dr/dc = 0..2 for -1..+1
  input  logic [8:0]      valid_i,  // 0 marks a neighbour outside the image
  output logic [DW-1:0]   pix_o
);

  localparam logic signed [ACC_W-1:0] KC     = ACC_W'(K_CENTRE);
  localparam logic signed [ACC_W-1:0] KN     = ACC_W'(K_NEIGH);
  localparam logic signed [ACC_W-1:0] LO_S   = ACC_W'(CLAMP_MIN);
  localparam logic signed [ACC_W-1:0] HI_S   = ACC_W'(CLAMP_MAX);
  localparam int                      CENTRE = 4;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] tap_s;

  // Weighted sum of in-image taps, then clamp to the pixel range
  always_comb begin
    acc   = '0;
    tap_s = '0;
    for (int i = 0; i < 9; i++) begin
      tap_s = $signed({{(ACC_W-DW){1'b0}}, taps_i[i*DW +: DW]});
      if (valid_i[i]) begin
        acc = acc + ((i == CENTRE) ? KC : KN) * tap_s;
      end
    end
    if (acc < LO_S) begin
      pix_o = DW'(CLAMP_MIN);
    end else if (acc > HI_S) begin
      pix_o = DW'(CLAMP_MAX);
    end else begin
      pix_o = acc[DW-1:0];
    end
  end

endmodule

// File: rtl/sharpen_filter.sv
// rtl/sharpen_filter.sv - in-place 3x3 sharpen over a 64x64 gray image using a 3-row line buffer
module sharpen_filter
  import img_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3*DW-1:0]   in_pix,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              out_we,
  output logic [3*DW-1:0]   out_pix,
  output logic              busy,
  output logic              filter_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_DIM - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ld_row_q, ld_row_d;
  logic [ADDR_W-1:0]   wr_row_q, wr_row_d;
  logic [ADDR_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]   col_q, col_d;
  logic                we_q, we_d;
  logic [3*DW-1:0]     pix_q, pix_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Original gray values of the three rows around the row being written
  logic [DW-1:0]       lbuf_q [0:2][0:IMG_DIM-1];

  logic [ADDR_W-1:0]   k_row, k_col;
  logic [ADDR_W:0]     rr, cc;
  logic [9*DW-1:0]     k_taps;
  logic [8:0]          k_valid;
  logic [DW-1:0]       k_pix;
  logic                unused_rb;

  assign unused_rb = ^{in_pix[3*DW-1:2*DW], in_pix[DW-1:0]};

  // Pixel whose result is registered at this edge: the next WRITE coordinate
  always_comb begin
    k_row = wr_row_q;
    k_col = col_q + 1'b1;
    if (state_q == LOAD) begin
      k_row = ld_row_q - 1'b1;
      k_col = '0;
    end else if (col_q == LAST) begin
      k_row = LAST;
      k_col = '0;
    end
  end

  // Gather the 3x3 window; rr/cc carry a +1 offset so row/col -1 maps to 0
  always_comb begin
    k_taps  = '0;
    k_valid = '0;
    rr      = '0;
    cc      = '0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        rr = {1'b0, k_row} + 7'(dr);
        cc = {1'b0, k_col} + 7'(dc);
        if (rr != '0 && rr <= 7'(IMG_DIM) && cc != '0 && cc <= 7'(IMG_DIM)) begin
          k_valid[dr*3+dc] = 1'b1;
          k_taps[(dr*3+dc)*DW +: DW] = lbuf_q[slot_of(rr - 7'd1)][ADDR_W'(cc - 7'd1)];
        end
      end
    end
  end

  sharpen_kernel u_kernel (
    .taps_i  (k_taps),
    .valid_i (k_valid),
    .pix_o   (k_pix)
  );

  // Pass sequencing: L0 L1 W0 L2 W1 ... L63 W62 W63, then DONE
  always_comb begin
    state_d  = state_q;
    ld_row_d = ld_row_q;
    wr_row_d = wr_row_q;
    row_d    = row_q;
    col_d    = col_q;
    we_d     = 1'b0;
    pix_d    = '0;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = LOAD;
          ld_row_d = '0;
          row_d    = '0;
          col_d    = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      LOAD: begin
        if (col_q != LAST) begin
          col_d = col_q + 1'b1;
        end else if (ld_row_q == '0) begin
          ld_row_d = ADDR_W'(1);
          row_d    = ADDR_W'(1);
          col_d    = '0;
        end else begin
          state_d  = WRITE;
          wr_row_d = ld_row_q - 1'b1;
          row_d    = ld_row_q - 1'b1;
          col_d    = '0;
          we_d     = 1'b1;
          pix_d    = {{DW{1'b0}}, k_pix, {DW{1'b0}}};
        end
      end
      WRITE: begin
        if (col_q != LAST) begin
          col_d = col_q + 1'b1;
          we_d  = 1'b1;
          pix_d = {{DW{1'b0}}, k_pix, {DW{1'b0}}};
        end else if (wr_row_q == LAST) begin
          state_d = DONE;
          row_d   = '0;
          col_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (ld_row_q != LAST) begin
          state_d  = LOAD;
          ld_row_d = ld_row_q + 1'b1;
          row_d    = ld_row_q + 1'b1;
          col_d    = '0;
        end else begin
          wr_row_d = LAST;
          row_d    = LAST;
          col_d    = '0;
          we_d     = 1'b1;
          pix_d    = {{DW{1'b0}}, k_pix, {DW{1'b0}}};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts a pass immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ld_row_q <= '0;
      wr_row_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      we_q     <= 1'b0;
      pix_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ld_row_q <= ld_row_d;
      wr_row_q <= wr_row_d;
      row_q    <= row_d;
      col_q    <= col_d;
      we_q     <= we_d;
      pix_q    <= pix_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Capture the G byte of each loaded pixel; contents are refilled every pass
  always_ff @(posedge clk) begin
    if (state_q == LOAD) begin
      lbuf_q[slot_of({1'b0, ld_row_q})][col_q] <= in_pix[2*DW-1:DW];
    end
  end

  assign row         = row_q;
  assign col         = col_q;
  assign out_we      = we_q;
  assign out_pix     = pix_q;
  assign busy        = busy_q;
  assign filter_done = done_q;

endmodule

// File: tb/tb_sharpen_filter.sv
// tb/tb_sharpen_filter.sv - directed self-checking bench for sharpen_filter with a 64x64 memory model
module tb_sharpen_filter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [23:0] in_pix;
  logic [5:0]  row, col;
  logic        out_we;
  logic [23:0] out_pix;
  logic        busy, filter_done;

  always #5 clk = ~clk;

  sharpen_filter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .in_pix      (in_pix),
    .row         (row),
    .col         (col),
    .out_we      (out_we),
    .out_pix     (out_pix),
    .busy        (busy),
    .filter_done (filter_done)
  );

  logic [23:0] mem [0:63][0:63];
  assign in_pix = mem[row][col];

  int          asserts = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          wr_idx = 0;
  int          ord_err = 0;
  logic        load_req = 1'b0;
  int          img_sel = 0;
  logic [7:0]  img_g = 8'd0;

  function automatic logic [23:0] img_pix(input int sel, input logic [7:0] g, input int r, input int c);
    case (sel)
      0: return {8'd0, g, 8'd0};
      2: return (r == 10 && c == 10) ? 24'h00FF00 : 24'h000000;
      3: return 24'hFF00FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Memory model: image load on request, otherwise apply DUT writes and track write order
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (load_req) begin
      for (int r = 0; r < 64; r++)
        for (int c = 0; c < 64; c++)
          mem[r][c] <= img_pix(img_sel, img_g, r, c);
      wr_cnt  <= 0;
      wr_idx  <= 0;
      ord_err <= 0;
    end else if (out_we) begin
      mem[row][col] <= out_pix;
      wr_cnt <= wr_cnt + 1;
      wr_idx <= wr_idx + 1;
      if ({row, col} !== 12'(wr_idx)) ord_err <= ord_err + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    asserts++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic load_image(input int sel, input logic [7:0] g);
    @(negedge clk);
    img_sel  = sel;
    img_g    = g;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_pass(input string tag, output int busy_n, output int lat);
    int c0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    chk({tag, "_enter_load"}, {29'd0, busy, filter_done, out_we}, 32'b100);
    busy_n = busy ? 1 : 0;
    for (int i = 0; i < 9000 && !filter_done; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    lat = cyc - c0;
    chk({tag, "_done_seen"}, {31'd0, filter_done}, 32'd1);
  endtask

  task automatic check_uniform(input string tag, input logic [23:0] v_int, input logic [23:0] v_edge,
                               input logic [23:0] v_corner);
    int err;
    int n;
    logic [23:0] e;
    err = 0;
    for (int r = 0; r < 64; r++) begin
      for (int c = 0; c < 64; c++) begin
        n = ((r == 0 || r == 63) ? 1 : 0) + ((c == 0 || c == 63) ? 1 : 0);
        e = (n == 0) ? v_int : (n == 1) ? v_edge : v_corner;
        if (mem[r][c] !== e) err++;
      end
    end
    chk(tag, err, 0);
  endtask

  function automatic int count_nonzero();
    int n;
    n = 0;
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 64; c++)
        if (mem[r][c] !== 24'h000000) n++;
    return n;
  endfunction

  initial begin
    int bn, lat, c0, hits;
    logic found;

    // 1: reset state, no writes while idle
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_row", row, 0);
    chk("rst_col", col, 0);
    chk("rst_we", out_we, 0);
    chk("rst_pix", out_pix, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", filter_done, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_write", wr_cnt, 0);
    chk("idle_busy", busy, 0);

    // 2: uniform G=100, timing and border values
    load_image(0, 8'd100);
    run_pass("u100", bn, lat);
    chk("u100_busy_cycles", bn, 8192);
    chk("u100_done_latency", lat, 8192);
    check_uniform("u100_pixels", 24'h006400, 24'h00FF00, 24'h00FF00);
    chk("u100_px00", mem[0][0], 24'h00FF00);
    chk("u100_px05", mem[0][5], 24'h00FF00);
    chk("u100_px55", mem[5][5], 24'h006400);
    chk("u100_writes", wr_cnt, 4096);
    chk("u100_order", ord_err, 0);
    chk("u100_done_state", {26'd0, row, col, out_we, busy, filter_done}, {26'd0, 6'd0, 6'd0, 3'b001});

    // 3: all-zero image, write count and order
    load_image(1, 8'd0);
    run_pass("zero", bn, lat);
    chk("zero_nonzero", count_nonzero(), 0);
    chk("zero_writes", wr_cnt, 4096);
    chk("zero_order", ord_err, 0);

    // 4: single bright pixel at (10,10)
    load_image(2, 8'd0);
    run_pass("dot", bn, lat);
    chk("dot_centre", mem[10][10], 24'h00FF00);
    chk("dot_nw", mem[9][9], 24'h000000);
    chk("dot_e", mem[10][11], 24'h000000);
    chk("dot_s", mem[11][10], 24'h000000);
    chk("dot_nonzero", count_nonzero(), 1);

    // 5: R and B ignored
    load_image(3, 8'd0);
    run_pass("rb", bn, lat);
    chk("rb_nonzero", count_nonzero(), 0);
    chk("rb_writes", wr_cnt, 4096);

    // 6: start while busy ignored, reset during W30, then a clean pass
    load_image(0, 8'd100);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 9000 && !found; i++) begin
      @(negedge clk);
      if (out_we && row == 6'd5) found = 1'b1;
    end
    chk("busy_start_reach_w5", found, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 9000 && !found; i++) begin
      @(negedge clk);
      if (out_we && row == 6'd30 && col == 6'd5) found = 1'b1;
    end
    chk("busy_start_reach_w30", found, 1);
    chk("busy_start_timing", cyc - c0, 3973);
    chk("busy_start_order", ord_err, 0);
    chk("writes_before_reset", wr_cnt, 1925);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {row, col, out_we, out_pix, busy, filter_done}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    hits = wr_cnt;
    chk("abort_no_more_writes", hits, 1925);
    chk("abort_idle", {29'd0, out_we, busy, filter_done}, 0);

    load_image(0, 8'd50);
    run_pass("u50", bn, lat);
    check_uniform("u50_pixels", 24'h003200, 24'h00C800, 24'h00FF00);
    chk("u50_writes", wr_cnt, 4096);
    chk("u50_order", ord_err, 0);
    chk("u50_busy_cycles", bn, 8192);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
